// File: rtl/key_step_ctrl.sv
// key_step_ctrl: debounces the active-low board keys into clean step, cpu reset, run/step mode and display-test controls.
module key_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic       step_en,
    output logic       cpu_reset,
    output logic       run_mode,
    output logic       disp_test
);
    localparam int CW = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW = $clog2(RUN_DIV);

    typedef enum logic {STEP, RUN} state_t;

    state_t         state, state_nxt;
    logic [3:0]     sync1, sync2, level_q, press;
    logic [CW-1:0]  cnt [4];
    logic [DW-1:0]  div;
    logic           wrap, step_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

    // A key's level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_level <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    key_level[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= STEP;
        else        state <= state_nxt;
    end

    always_comb begin
        press     = key_level & ~level_q;
        wrap      = div == DW'(RUN_DIV - 1);
        state_nxt = key_level[1] ? STEP : press[3] ? (state == RUN ? STEP : RUN) : state;
    end

    always_comb begin
        run_mode  = state == RUN;
        disp_test = key_level[2];
        step_nxt  = !key_level[1] && !press[3] && (state == RUN ? wrap : press[0]);
    end

    // The divider only runs while staying in RUN, so it restarts from 0 on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= '0;
            cpu_reset <= 1'b1;
            step_en   <= 1'b0;
            div       <= '0;
        end else begin
            level_q   <= key_level;
            cpu_reset <= key_level[1];
            step_en   <= step_nxt;
            div       <= (state == RUN && state_nxt == RUN && !wrap) ? div + 1'b1 : '0;
        end
    end
endmodule

// File: doc/key_step_ctrl.md
Name: key_step_ctrl

Overview:
Input-side conditioner for the up3 board top. It turns the raw active-low KEY pushbuttons into clean, debounced, single-cycle control events for the processor: a step enable, a processor reset, a run/step mode toggle and a display-test level. It replaces direct use of a raw key as the processor clock. The processor then runs on the board clock, advancing only when step_en pulses.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required before a key's debounced level changes (10 ms at 50 MHz).
RUN_DIV, 25000000, clocks between step_en pulses in RUN mode (2 Hz at 50 MHz); minimum 2.

Ports:
clk  input  1  board clock; all state is on its rising edge.
reset  input  1  asynchronous, active-low global reset.
key_n  input  4  raw pushbuttons, active-low. Bit 0 is step, bit 1 is cpu reset, bit 2 is display test, bit 3 is mode toggle.
key_level  output  4  debounced pressed level per key (1 = pressed).
step_en  output  1  one-clock pulse; the processor advances one state per pulse.
cpu_reset  output  1  active-high processor reset.
run_mode  output  1  1 = RUN (free-running steps), 0 = STEP (manual steps).
disp_test  output  1  equals key_level[2]; drives display blank/test.

Behaviour:
- Reset values (while reset = 0):
  - key_level = 0, step_en = 0, run_mode = 0, disp_test = 0.
  - cpu_reset = 1.
  - All synchronizers, debounce counters and the run divider are cleared.
  - The mode FSM is in STEP.
- Synchronizer: each key_n bit is inverted, then passed through 2 flops. The raw input is never used combinationally.
- Debounce, per key:
  - The counter clears whenever the synced value equals key_level[i].
  - Otherwise it increments by 1.
  - When it reaches DEBOUNCE_CYCLES-1, key_level[i] takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - A glitch shorter than DEBOUNCE_CYCLES clocks never changes key_level.
  - Latency from a clean raw edge to key_level change is DEBOUNCE_CYCLES+2 clocks.
- Edge detect: press_i is 1 for exactly the one clock after key_level[i] rises. Releases produce no event.
- cpu_reset: a registered copy of key_level[1], so it asserts 1 clock after key_level[1] rises. Out of global reset with no key pressed, it deasserts on the first clk edge.
- Mode FSM, states STEP and RUN:
  - STEP -> RUN on press_3.
  - RUN -> STEP on press_3.
  - Any state -> STEP while key_level[1] = 1.
  - run_mode = (state == RUN).
- step_en:
  - In STEP, step_en = press_0, registered, so it pulses 1 clock after press_0.
  - In RUN, a divider counts 0..RUN_DIV-1 and wraps. step_en pulses on the wrap clock, so pulses are exactly RUN_DIV clocks apart. The divider clears on entry to RUN.
  - The first RUN pulse occurs RUN_DIV clocks after entering RUN.
  - press_0 is ignored in RUN.
- Priority for simultaneous events:
  1. cpu_reset level, which forces STEP, clears the divider and suppresses step_en.
  2. press_3, which toggles mode with no step_en in that clock.
  3. press_0 or divider wrap.
- step_en is never high for 2 consecutive clocks, and never high while cpu_reset = 1.
- Reset mid-operation: asserting reset asynchronously forces all reset values. Debounce state is lost, so a key held across reset release is re-debounced from 0.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=8):
- Hold reset low 3 clocks, keys released -> cpu_reset=1, all other outputs 0 during reset; cpu_reset=0 one clock after release; step_en stays 0 for 50 clocks.
- key_n[0] low for 3 clocks, then high -> key_level[0] never rises, step_en never pulses. key_n[0] low for 20 clocks -> key_level[0] rises at clock 6, step_en high at clock 7 only; release produces no pulse.
- Bounce key_n[0] 1,0,1,0 per clock, then hold low -> exactly one step_en pulse.
- Press key 3 -> run_mode=1. step_en then pulses at 8, 16 and 24 clocks after entry. Pressing key 0 in RUN adds no pulse. Pressing key 3 again -> run_mode=0 and pulses stop.
- In RUN, press key 1 -> cpu_reset=1 one clock after key_level[1] rises, run_mode=0, no step_en while held. After release -> cpu_reset=0 and state STEP.
- Key 0 and key 3 debounced-rise in the same clock from STEP -> run_mode=1, no step_en in that clock. Key 2 held -> disp_test=1 after 6 clocks; released -> 0 after 6 clocks.
